// File: rtl/uart_receiver.sv
// 16x-oversampled 8N1 UART receiver with glitch rejection, framing/overrun flags and valid/ready output.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err output.
module uart_receiver #(
  parameter int CLOCK_RATE = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enabled,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam int DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] MID_BIT   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_BIT  = SW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t          state;
  logic            rxMeta, rx_s;
  logic [TW-1:0]   tickCnt;
  logic [SW-1:0]   sampleCnt;
  logic [2:0]      bitIdx;
  logic [7:0]      shiftReg;
`ifdef UART_RX_PARITY_EN
  logic            parityBit;
`endif
  logic            tick;
  logic            startDetect;

  assign tick        = (tickCnt == TICK_LAST);
  assign startDetect = (state == IDLE) && enabled && !rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      rxMeta <= rx;
      rx_s   <= rxMeta;
    end
  end

  // Restarting on the falling edge keeps every sample point a fixed offset into the bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tickCnt <= '0;
    else if (startDetect || tick)
      tickCnt <= '0;
    else
      tickCnt <= tickCnt + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sampleCnt  <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
      data       <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBit  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (valid && ready)
        valid <= 1'b0;

      if (!enabled) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (!rx_s) begin
            state     <= START;
            busy      <= 1'b1;
            sampleCnt <= '0;
          end
          START: if (tick) begin
            if (sampleCnt == MID_BIT) begin
              sampleCnt <= '0;
              bitIdx    <= '0;
              if (rx_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else
                state <= DATA;
            end else
              sampleCnt <= sampleCnt + SW'(1);
          end
          DATA: if (tick) begin
            if (sampleCnt == FULL_BIT) begin
              sampleCnt <= '0;
              shiftReg  <= {rx_s, shiftReg[7:1]};
              bitIdx    <= bitIdx + 3'd1;
              if (bitIdx == 3'd7)
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
            end else
              sampleCnt <= sampleCnt + SW'(1);
          end
`ifdef UART_RX_PARITY_EN
          PARITY: if (tick) begin
            if (sampleCnt == FULL_BIT) begin
              sampleCnt <= '0;
              parityBit <= rx_s;
              state     <= STOP;
            end else
              sampleCnt <= sampleCnt + SW'(1);
          end
`endif
          STOP: if (tick) begin
            if (sampleCnt == FULL_BIT) begin
              sampleCnt <= '0;
              if (!rx_s) begin
                frame_err <= 1'b1;
                state     <= WAIT_IDLE;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                if (^{shiftReg, parityBit})
                  parity_err <= 1'b1;
                else
`endif
                begin
                  data    <= shiftReg;
                  valid   <= 1'b1;
                  overrun <= valid && !ready;
                end
              end
            end else
              sampleCnt <= sampleCnt + SW'(1);
          end
          WAIT_IDLE: if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames push expected bytes, a monitor pops on each presented byte.
module tb_uart_receiver;

  localparam int BIT = 432;

  logic       clk;
  logic       rst_n;
  logic       enabled;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         parityErrCount = 0;
`endif

  int         checks = 0;
  int         failures = 0;
  int         validCycles = 0;
  int         frameErrCount = 0;
  int         overrunCount = 0;
  logic [7:0] expQ[$];
  logic [7:0] expByte;
  logic       prevValid;

  uart_receiver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enabled   (enabled),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic waitClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendData(input logic [7:0] b);
    rx = 1'b0;
    waitClks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      waitClks(BIT);
    end
  endtask

  // Full well-formed frame; the byte is expected back through the scoreboard.
  task automatic applyStimulus(input logic [7:0] b);
    expQ.push_back(b);
    sendData(b);
`ifdef UART_RX_PARITY_EN
    rx = ^b;
    waitClks(BIT);
`endif
    rx = 1'b1;
    waitClks(BIT);
  endtask

  // Monitor: counts pulses and checks every newly presented byte against the queue.
  initial begin
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (valid) validCycles++;
      if (frame_err) frameErrCount++;
      if (overrun) overrunCount++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) parityErrCount++;
`endif
      if ((valid && !prevValid) || overrun) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_byte actual=%0h required=none", data);
        end else begin
          expByte = expQ.pop_front();
          checkOutput("rx_byte", {24'd0, data}, {24'd0, expByte});
        end
      end
      prevValid = valid;
    end
  end

  initial begin
    int v0, f0, o0;
    rst_n   = 1'b0;
    enabled = 1'b1;
    ready   = 1'b1;
    rx      = 1'b1;
    waitClks(5);
    checkOutput("reset_data", {24'd0, data}, 32'h0);
    checkOutput("reset_valid", {31'd0, valid}, 32'h0);
    checkOutput("reset_busy", {31'd0, busy}, 32'h0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'h0);
    checkOutput("reset_overrun", {31'd0, overrun}, 32'h0);
    rst_n = 1'b1;
    waitClks(BIT);

    $display("[TB] clean byte 0xA5");
    v0 = validCycles; f0 = frameErrCount;
    applyStimulus(8'hA5);
    checkOutput("a5_valid_width", validCycles - v0, 1);
    checkOutput("a5_frame_err", frameErrCount - f0, 0);
    checkOutput("a5_busy_after", {31'd0, busy}, 32'h0);
    checkOutput("a5_data_held", {24'd0, data}, 32'hA5);

    $display("[TB] start-bit glitch");
    v0 = validCycles;
    rx = 1'b0;
    waitClks(20);
    checkOutput("glitch_busy_rises", {31'd0, busy}, 32'h1);
    waitClks(180);
    rx = 1'b1;
    waitClks(100);
    checkOutput("glitch_busy_clears", {31'd0, busy}, 32'h0);
    waitClks(BIT);
    checkOutput("glitch_no_valid", validCycles - v0, 0);

    $display("[TB] framing error on 0x3C");
    v0 = validCycles; f0 = frameErrCount;
    sendData(8'h3C);
`ifdef UART_RX_PARITY_EN
    rx = ^8'h3C;
    waitClks(BIT);
`endif
    rx = 1'b0;
    waitClks(BIT + 300);
    checkOutput("frame_err_pulses", frameErrCount - f0, 1);
    checkOutput("frame_busy_held", {31'd0, busy}, 32'h1);
    waitClks(BIT - 300);
    rx = 1'b1;
    waitClks(20);
    checkOutput("frame_busy_clears", {31'd0, busy}, 32'h0);
    checkOutput("frame_no_valid", validCycles - v0, 0);
    waitClks(BIT);

    $display("[TB] overrun 0x11 then 0x22");
    ready = 1'b0;
    o0 = overrunCount;
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    checkOutput("overrun_pulses", overrunCount - o0, 1);
    checkOutput("overrun_valid_held", {31'd0, valid}, 32'h1);
    checkOutput("overrun_data", {24'd0, data}, 32'h22);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checkOutput("accept_clears_valid", {31'd0, valid}, 32'h0);
    ready = 1'b1;

    $display("[TB] reset during data bit 4 of 0xFF");
    rx = 1'b0;
    waitClks(BIT);
    rx = 1'b1;
    waitClks(4 * BIT + BIT / 2);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_data", {24'd0, data}, 32'h0);
    checkOutput("midreset_busy", {31'd0, busy}, 32'h0);
    checkOutput("midreset_valid", {31'd0, valid}, 32'h0);
    waitClks(10);
    rst_n = 1'b1;
    waitClks(BIT);
    applyStimulus(8'h5A);
    checkOutput("after_reset_busy", {31'd0, busy}, 32'h0);

    $display("[TB] disable mid-frame");
    v0 = validCycles;
    rx = 1'b0;
    waitClks(3 * BIT);
    enabled = 1'b0;
    waitClks(2);
    checkOutput("disable_busy_clears", {31'd0, busy}, 32'h0);
    waitClks(2 * BIT);
    rx = 1'b1;
    waitClks(6 * BIT);
    enabled = 1'b1;
    waitClks(BIT);
    checkOutput("disable_no_valid", validCycles - v0, 0);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity on 0x07");
    applyStimulus(8'h07);
    v0 = validCycles; f0 = parityErrCount;
    sendData(8'h07);
    rx = 1'b0;
    waitClks(BIT);
    rx = 1'b1;
    waitClks(BIT);
    checkOutput("parity_err_pulses", parityErrCount - f0, 1);
    checkOutput("parity_no_valid", validCycles - v0, 0);
`endif

    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage; the downstream counterpart of the transmitter.
- Consumes an 8N1 serial line (idle high, start bit low, 8 data bits LSB first, stop bit high).
- Presents each received byte on a valid/ready handshake to the consuming logic (command decoder / RX FIFO).
- Uses 16x oversampling with mid-bit sampling, start-bit glitch rejection, and framing/overrun error reporting.

Parameters:
- CLOCK_RATE, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line bit rate in bits/s.
- OVERSAMPLE, 16: samples per bit; must be a power of two, at least 8.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- enabled  input  1  receiver enable; while low, the FSM is held in IDLE and no bytes are captured.
- rx  input  1  asynchronous serial line; synchronised internally.
- data  output  8  last received byte; stable while valid is high.
- valid  output  1  byte available; held high until accepted.
- ready  input  1  consumer accepts the byte when valid && ready on a rising clk edge.
- busy  output  1  high from start-bit detection until return to IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a new byte completed while valid was still high.

Behaviour:
- Reset (rst_n low, asynchronous): data=8'h00, valid=0, busy=0, frame_err=0, overrun=0, FSM=IDLE, all counters 0, synchroniser flops=1.
- Sample tick:
  - DIV = CLOCK_RATE/(BAUD_RATE*OVERSAMPLE), integer truncation. Defaults give DIV=27.
  - Counter runs 0..DIV-1 and emits a one-clk tick at DIV-1.
  - Counter restarts at 0 on start-bit detection so sampling phase aligns to the falling edge.
- Synchroniser: 2 flops on rx. All logic uses the synchronised value rx_s. Input latency is 2 clk.
- FSM states IDLE, START, DATA, STOP, WAIT_IDLE:
  - IDLE: on rx_s==0 and enabled, go to START, busy=1, sample count=0.
  - START:
    - At sample count OVERSAMPLE/2-1 (mid start bit): if rx_s==1, treat as a glitch and go to IDLE with busy=0. Otherwise reset the sample count and go to DATA.
  - DATA:
    - Every OVERSAMPLE ticks, sample rx_s into the shift register MSB and shift right (LSB first).
    - A 3-bit bit index advances on each sample; after index 7 is sampled, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - If 1: load data, set valid, go to IDLE, busy=0.
    - If 0: pulse frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1 (break condition), then go to IDLE with busy=0.
- Handshake:
  - valid clears on the clk edge where valid && ready.
  - A byte completing on the same edge as acceptance: valid stays 1, data takes the new byte, no overrun.
  - A byte completing while valid && !ready: data is overwritten, valid stays 1, overrun pulses for 1 cycle.
- Disable mid-frame: when enabled goes low, the FSM returns to IDLE next clk, busy=0, and the partial byte is discarded. valid/data are unaffected (a pending byte may still be accepted).
- Latency: valid rises 1 clk after the stop-bit mid-sample, which is about 9.5 bit periods plus 3 clk after the start-bit falling edge.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - Frame is 8E1: a parity bit follows data bit 7, and a PARITY state samples it mid-bit.
  - Adds output parity_err (1 bit), a one-cycle pulse when the XOR of data and the parity bit is 1.
  - On parity error the byte is discarded and valid is not set.
  - The stop bit is still checked; a frame error takes precedence and suppresses parity_err.
- When undefined: 8N1 only, no PARITY state, no parity_err port.

Test Plan:
- Defaults (bit period 432 clk); drive 8'hA5 8N1 with ready=1 -> valid pulse 1 cycle, data=8'hA5, frame_err=0, busy low after the stop sample.
- 200-clk low glitch on idle rx -> busy rises, then returns to IDLE at mid start bit; valid never asserts.
- Send 8'h3C with stop bit held low for 2 bit periods, then high -> frame_err pulses once, valid stays 0, busy stays high until rx returns high.
- ready=0; send 8'h11 then 8'h22 back-to-back -> valid stays 1, overrun pulses once, data=8'h22; ready=1 for one cycle -> valid=0.
- Deassert rst_n mid data bit 4 of 8'hFF -> all outputs 0 immediately; after release, a clean 8'h5A is received correctly.
- With UART_RX_PARITY_EN: 8'h07 with parity bit 1 -> data=8'h07, valid=1; same byte with parity bit 0 -> parity_err pulse, valid=0.
